// File: rtl/sum16_serie_pkg.sv
// Types and constants for the nibble-serial adder sum16_serie.
package sum16_serie_pkg;

`include "sum16_serie_defs.vh"

    localparam int NIB_W = `SUM16_SERIE_NIB_W;

    typedef enum logic [1:0] {
        IDLE = `SUM16_SERIE_ST_IDLE,
        SUMA = `SUM16_SERIE_ST_SUMA,
        FIN  = `SUM16_SERIE_ST_FIN
    } state_t;

    // Signed overflow of the top nibble: carry into its MSB xor carry out of it.
    function automatic logic nib_ovf(input logic a_msb, input logic b_msb,
                                     input logic s_msb, input logic c_msb_out);
        return (a_msb ^ b_msb ^ s_msb) ^ c_msb_out;
    endfunction

endpackage

// File: rtl/sum16_serie_defs.vh
// Shared constants for sum16_serie: FSM state encodings and nibble width.
`ifndef SUM16_SERIE_DEFS_VH
`define SUM16_SERIE_DEFS_VH

`define SUM16_SERIE_NIB_W     4
`define SUM16_SERIE_ST_IDLE   2'b00
`define SUM16_SERIE_ST_SUMA   2'b01
`define SUM16_SERIE_ST_FIN    2'b10

`endif

// File: rtl/sum4.sv
// 4-bit ripple adder cell with carry in/out.
module sum4 (
    output logic [3:0] s,
    output logic       c_out,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in
);

    assign {c_out, s} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};

endmodule

// File: rtl/sum16_serie.sv
// Nibble-serial adder: one 4-bit slice per cycle through a single sum4 cell.
// Define SUM16_SERIE_OVF_EN to add the two's-complement overflow output ovf.
module sum16_serie
    import sum16_serie_pkg::*;
#(
    parameter int N_NIB = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NIB_W*N_NIB-1:0] a,
    input  logic [NIB_W*N_NIB-1:0] b,
    input  logic                   c_in,
    output logic                   ready,
    output logic                   done,
    output logic [NIB_W*N_NIB-1:0] s,
    output logic                   c_out
`ifdef SUM16_SERIE_OVF_EN
    ,
    output logic                   ovf
`endif
);

    localparam int W     = NIB_W * N_NIB;
    localparam int IDX_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;

    state_t             state_q;
    state_t             state_d;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       s_q;
    logic               carry_q;
    logic               c_out_q;
    logic [IDX_W-1:0]   idx_q;
    logic               last_nib;
    logic               accept;
    int                 nib_base;
    logic [NIB_W-1:0]   a_nib;
    logic [NIB_W-1:0]   b_nib;
    logic [NIB_W-1:0]   sum_nib;
    logic               nib_cout;

    assign accept   = (state_q == IDLE) && start;
    assign last_nib = (idx_q == IDX_W'(N_NIB - 1));
    assign nib_base = int'(idx_q) * NIB_W;
    assign a_nib    = a_q[nib_base +: NIB_W];
    assign b_nib    = b_q[nib_base +: NIB_W];

    sum4 u_sum4 (
        .s    (sum_nib),
        .c_out(nib_cout),
        .a    (a_nib),
        .b    (b_nib),
        .c_in (carry_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The unused encoding 2'b11 falls through to the default and recovers to IDLE.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_d = SUMA;
                end
            end
            SUMA: begin
                if (last_nib) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand latches carry no reset: they are always reloaded on acceptance.
    always_ff @(posedge clk) begin
        if (accept && rst_n) begin
            a_q <= a;
            b_q <= b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q     <= '0;
            c_out_q <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            s_q     <= '0;
            c_out_q <= 1'b0;
            carry_q <= c_in;
            idx_q   <= '0;
        end else if (state_q == SUMA) begin
            s_q[nib_base +: NIB_W] <= sum_nib;
            carry_q                <= nib_cout;
            if (last_nib) begin
                c_out_q <= nib_cout;
                idx_q   <= '0;
            end else begin
                idx_q   <= idx_q + IDX_W'(1);
            end
        end
    end

`ifdef SUM16_SERIE_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if ((state_q == SUMA) && last_nib) begin
            ovf_q <= nib_ovf(a_nib[NIB_W-1], b_nib[NIB_W-1], sum_nib[NIB_W-1], nib_cout);
        end
    end

    assign ovf = ovf_q;
`endif

    assign s     = s_q;
    assign c_out = c_out_q;

endmodule
